unsigned_mul_arbiter: RTL

Round-robin arbiter that shares one unsigned multiplier stage (P = A × B, 1-clk registered, clock-enable gated) between `req_n` requesters. Each requester presents operands on a valid/ready channel. The block grants at most one request per cycle and drives the multiplier clock enable. It returns the product with the requester ID on a single valid/ready result channel. It sits between the convolution/pooling sub-units and the DSP resource, so that several low-rate users share one DSP slice.

---
 rtl/unsigned_mul_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/unsigned_mul_arbiter.sv
// ---------------------------------------------------------------------------
// unsigned_mul_arbiter
//
// Shares one registered unsigned multiplier between req_n requesters.
// Each cycle, a round-robin search picks at most one valid requester. The
// search starts one past the last grant. The chosen operands feed the
// multiplier, and the product register doubles as the result register.
//
// Ports
//   clk          in   clock
//   rst          in   synchronous reset, active high
//   s_req_valid  in   [req_n]               per-requester request valid
//   s_req_ready  out  [req_n]               per-requester accept (one-hot or 0)
//   s_op_a       in   [req_n*op_a_width]    operand A, requester i at i*op_a_width
//   s_op_b       in   [req_n*op_b_width]    operand B, same packing
//   m_res_valid  out                        result valid
//   m_res_ready  in                         downstream accepts result
//   m_res_data   out  [output_width]        low output_width bits of A*B
//   m_res_id     out  [id_width]            requester that issued the result
// ---------------------------------------------------------------------------
module unsigned_mul_arbiter #(
    parameter int req_n            = 4,
    parameter int op_a_width       = 16,
    parameter int op_b_width       = 16,
    parameter int output_width     = 32,
    parameter int id_width         = 2,
    parameter int simulation_delay = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [req_n-1:0]                 s_req_valid,
    output logic [req_n-1:0]                 s_req_ready,
    input  logic [req_n*op_a_width-1:0]      s_op_a,
    input  logic [req_n*op_b_width-1:0]      s_op_b,
    output logic                             m_res_valid,
    input  logic                             m_res_ready,
    output logic [output_width-1:0]          m_res_data,
    output logic [id_width-1:0]              m_res_id
);

    localparam int PW = op_a_width + op_b_width;

    // Elaboration-time parameter sanity checks. simulation_delay only models
    // register update delay in behavioural sims and has no hardware meaning.
    if (req_n < 2 || req_n > 16) begin : g_bad_req_n
        $error("unsigned_mul_arbiter: req_n must be 2..16");
    end
    if (output_width > PW) begin : g_bad_out_w
        $error("unsigned_mul_arbiter: output_width exceeds op_a_width+op_b_width");
    end
    if (id_width < $clog2(req_n)) begin : g_bad_id_w
        $error("unsigned_mul_arbiter: id_width too small for req_n");
    end
    if (simulation_delay < 0) begin : g_bad_sim_dly
        $error("unsigned_mul_arbiter: simulation_delay must be non-negative");
    end

    logic                    r_mul_vld;
    logic [output_width-1:0] r_mul_res;
    logic [id_width-1:0]     r_mul_id;
    logic [id_width-1:0]     r_last_grant;

    logic                    w_any;
    logic                    w_hi_found;
    logic [id_width-1:0]     w_hi_idx;
    logic [id_width-1:0]     w_lo_idx;
    logic [id_width-1:0]     w_gnt;
    logic                    w_issue_ok;
    logic                    w_issue;
    logic                    w_mul_ce;
    logic [op_a_width-1:0]   w_op_a;
    logic [op_b_width-1:0]   w_op_b;
    logic [output_width-1:0] w_res;

    // Round-robin search. The descending scan leaves the lowest matching index
    // in each slot. "hi" holds the first valid index above the last grant, and
    // "lo" holds the first valid index overall, which is the wrap-around case.
    always_comb begin
        w_any      = 1'b0;
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = req_n - 1; i >= 0; i--) begin
            if (s_req_valid[i]) begin
                w_any    = 1'b1;
                w_lo_idx = id_width'(i);
                if (id_width'(i) > r_last_grant) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = id_width'(i);
                end
            end
        end
        w_gnt = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    // The result slot is free now, or it drains this cycle.
    assign w_issue_ok = ~r_mul_vld | m_res_ready;
    assign w_issue    = w_issue_ok & w_any & ~rst;
    assign w_mul_ce   = w_issue;

    always_comb begin
        s_req_ready = '0;
        w_op_a      = '0;
        w_op_b      = '0;
        for (int i = 0; i < req_n; i++) begin
            if (w_gnt == id_width'(i)) begin
                s_req_ready[i] = w_issue;
                w_op_a         = s_op_a[i*op_a_width +: op_a_width];
                w_op_b         = s_op_b[i*op_b_width +: op_b_width];
            end
        end
    end

    // Full-width product, truncated to the low output_width bits.
    assign w_res = output_width'(PW'(w_op_a) * PW'(w_op_b));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_vld    <= 1'b0;
            r_mul_res    <= '0;
            r_mul_id     <= '0;
            r_last_grant <= id_width'(req_n - 1);
        end else begin
            if (w_issue_ok) begin
                r_mul_vld <= w_any;
            end
            if (w_mul_ce) begin
                r_mul_res    <= w_res;
                r_mul_id     <= w_gnt;
                r_last_grant <= w_gnt;
            end
        end
    end

    assign m_res_valid = r_mul_vld;
    assign m_res_data  = r_mul_res;
    assign m_res_id    = r_mul_id;

endmodule
